// File: rtl/maple_frame_receiver.sv
// Maple frame receiver: parses the header, checks the XOR checksum and queues payload bytes.
// Define MAPLE_ADDR_FILTER_EN to drop frames whose recipient differs from MY_ADDR.
module maple_frame_receiver #(
    parameter int         FIFO_DEPTH = 16,
    parameter int         FIFO_AW    = 4,
    parameter logic [7:0] MY_ADDR    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_active,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] hdr_cmd,
    output logic [7:0] hdr_dest,
    output logic [7:0] hdr_src,
    output logic [7:0] hdr_len,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       ovf_err
);
`ifdef MAPLE_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam logic [FIFO_AW:0] DEPTH = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECKSUM, WAIT_END, DONE} state_t;

    state_t          state, state_nxt;
    logic            prev_active, start;
    logic [1:0]      idx, idx_nxt;
    logic [7:0]      lrc, lrc_nxt;
    logic [9:0]      remaining, remaining_nxt;
    logic [3:0][7:0] shadow, shadow_nxt;
    logic            chk_bad, chk_bad_nxt, len_bad, len_bad_nxt, ovf_bad, ovf_bad_nxt;
    logic            miss, miss_nxt, push_req;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [FIFO_AW:0]   count;
    logic               full, pop, push_ok;

    assign start      = frame_active & ~prev_active;
    assign out_valid  = (count != '0);
    assign full       = (count == DEPTH);
    assign pop        = out_valid & out_ready;
    assign push_ok    = push_req & (~full | pop);
    assign rd_ptr_nxt = pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        lrc_nxt       = lrc;
        remaining_nxt = remaining;
        shadow_nxt    = shadow;
        chk_bad_nxt   = chk_bad;
        len_bad_nxt   = len_bad;
        ovf_bad_nxt   = ovf_bad;
        miss_nxt      = miss;
        push_req      = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    state_nxt     = HEADER;
                    idx_nxt       = '0;
                    lrc_nxt       = '0;
                    remaining_nxt = '0;
                    shadow_nxt    = '0;
                    chk_bad_nxt   = 1'b0;
                    len_bad_nxt   = 1'b0;
                    ovf_bad_nxt   = 1'b0;
                    miss_nxt      = 1'b0;
                end
            end
            HEADER: if (byte_valid) begin
                shadow_nxt[idx] = byte_data;
                lrc_nxt         = lrc ^ byte_data;
                idx_nxt         = idx + 2'd1;
                if (FILTER_EN && idx == 2'd1 && byte_data != MY_ADDR)
                    miss_nxt = 1'b1;
                if (idx == 2'd3) begin
                    remaining_nxt = {byte_data, 2'b00};
                    state_nxt     = (byte_data == 8'h00) ? CHECKSUM : PAYLOAD;
                end
            end
            PAYLOAD: if (byte_valid) begin
                lrc_nxt       = lrc ^ byte_data;
                remaining_nxt = remaining - 10'd1;
                if (!miss) begin
                    push_req = 1'b1;
                    if (full && !pop)
                        ovf_bad_nxt = 1'b1;
                end
                if (remaining == 10'd1)
                    state_nxt = CHECKSUM;
            end
            CHECKSUM: if (byte_valid) begin
                chk_bad_nxt = (byte_data != lrc);
                state_nxt   = WAIT_END;
            end
            WAIT_END: begin
                if (byte_valid)
                    len_bad_nxt = 1'b1;
                if (!frame_active)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        // A byte coinciding with the enable fall is absorbed above before the early-end override.
        if (!frame_active && (state == HEADER || state == PAYLOAD || state == CHECKSUM)) begin
            len_bad_nxt = 1'b1;
            state_nxt   = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev_active <= 1'b0;
            idx         <= '0;
            lrc         <= '0;
            remaining   <= '0;
            shadow      <= '0;
            chk_bad     <= 1'b0;
            len_bad     <= 1'b0;
            ovf_bad     <= 1'b0;
            miss        <= 1'b0;
            hdr_cmd     <= '0;
            hdr_dest    <= '0;
            hdr_src     <= '0;
            hdr_len     <= '0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_active <= frame_active;
            idx         <= idx_nxt;
            lrc         <= lrc_nxt;
            remaining   <= remaining_nxt;
            shadow      <= shadow_nxt;
            chk_bad     <= chk_bad_nxt;
            len_bad     <= len_bad_nxt;
            ovf_bad     <= ovf_bad_nxt;
            miss        <= miss_nxt;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
            // Status is registered on entry so it lines up with the single DONE cycle.
            if (state_nxt == DONE && !miss_nxt) begin
                frame_done <= 1'b1;
                frame_ok   <= ~(chk_bad_nxt | len_bad_nxt | ovf_bad_nxt);
                chk_err    <= chk_bad_nxt;
                len_err    <= len_bad_nxt;
                ovf_err    <= ovf_bad_nxt;
                hdr_cmd    <= shadow_nxt[0];
                hdr_dest   <= shadow_nxt[1];
                hdr_src    <= shadow_nxt[2];
                hdr_len    <= shadow_nxt[3];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            rd_ptr <= rd_ptr_nxt;
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            // Bypass the write when it lands on the new head, so a lone byte appears one clock later.
            out_data <= (push_ok && wr_ptr == rd_ptr_nxt) ? byte_data : mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= byte_data;
    end
endmodule

// File: doc/maple_frame_receiver.md
Name: maple_frame_receiver

Overview:
- Consumes the byte stream produced by the Maple bus data decoder (byte plus one-cycle ready strobe, framed by the decoder's enable).
- Parses the 4-byte Maple frame header (command, recipient, sender, length in 32-bit words) and counts the payload.
- Checks the trailing XOR checksum byte.
- Buffers payload bytes in a FIFO with a valid/ready interface toward the controller/host logic.

Parameters:
- FIFO_DEPTH, 16, payload FIFO depth in bytes; power of two, minimum 4.
- FIFO_AW, 4, FIFO address width; must equal log2(FIFO_DEPTH).
- MY_ADDR, 8'h00, recipient address accepted when MAPLE_ADDR_FILTER_EN is defined; unused otherwise.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- frame_active  input  1  high while a frame is on the bus (decoder enable).
- byte_data  input  8  decoded byte.
- byte_valid  input  1  one-cycle strobe; byte_data is valid this cycle.
- out_data  output  8  payload byte at FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- hdr_cmd  output  8  command of the last completed frame.
- hdr_dest  output  8  recipient of the last completed frame.
- hdr_src  output  8  sender of the last completed frame.
- hdr_len  output  8  length field (words) of the last completed frame.
- frame_done  output  1  one-cycle pulse at frame end.
- frame_ok  output  1  valid with frame_done: checksum good, length good, no overflow.
- chk_err  output  1  valid with frame_done: checksum mismatch.
- len_err  output  1  valid with frame_done: frame ended early, or extra bytes after the checksum.
- ovf_err  output  1  valid with frame_done: at least one payload byte dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0, FIFO flushed, FSM to IDLE.
  - Reset mid-frame abandons the frame; no frame_done is produced.
- Register prev_active each clk. Start condition = frame_active & ~prev_active.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM, WAIT_END, DONE.
- IDLE:
  - On the start condition → HEADER. Clear idx, lrc, remaining and the sticky error flags.
  - byte_valid in IDLE is ignored.
- HEADER:
  - Each byte_valid stores byte_data into shadow[idx] and sets lrc ^= byte_data.
  - On the 4th byte (idx==3): remaining = {byte_data,2'b00} (10 bits).
  - If byte_data==0 → CHECKSUM, else → PAYLOAD.
- PAYLOAD:
  - Each byte_valid sets lrc ^= byte_data, remaining -= 1, and pushes the byte to the FIFO.
  - When remaining reaches 0 → CHECKSUM.
- CHECKSUM:
  - On byte_valid: chk_bad = (byte_data != lrc) → WAIT_END.
- WAIT_END:
  - Any byte_valid sets len_bad.
  - When frame_active is low → DONE.
- Early end: frame_active low while in HEADER, PAYLOAD or CHECKSUM → set len_bad, → DONE.
  - If byte_valid and the fall coincide, the byte is processed first; the resulting state is then overridden to DONE.
- DONE (exactly one cycle), then → IDLE:
  - frame_done=1.
  - chk_err=chk_bad, len_err=len_bad, ovf_err=ovf_bad.
  - frame_ok = ~(chk_bad|len_bad|ovf_bad).
  - hdr_* outputs load from the shadow registers, even on error frames.
  - Header bytes never received keep shadow value 0.
- frame_ok and the error outputs are meaningful only while frame_done=1; they are 0 otherwise.
- A new start condition arriving while in DONE is not missed: DONE → HEADER directly, with the same clears as IDLE.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers and a (FIFO_AW+1)-bit count.
  - Pop when out_valid & out_ready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push drops the byte and sets ovf_bad; lrc still updates.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leave count unchanged.
  - out_data is registered from the head entry; first-byte latency is 1 clk after the push.
- The FIFO is not flushed between frames; the consumer drains it.

Optional Feature:
- Macro MAPLE_ADDR_FILTER_EN.
- Defined:
  - After the 2nd header byte, if byte_data != MY_ADDR the frame is marked miss.
  - A miss frame pushes no payload to the FIFO and produces no frame_done.
  - hdr_* outputs are not updated; the FSM still tracks the frame to its end.
- Not defined: every frame is processed; MY_ADDR is ignored.

Test Plan:
- Header 01,20,00,00 then checksum 21, then frame_active low → frame_done=1, frame_ok=1, hdr_cmd=01, hdr_dest=20, hdr_len=00, out_valid stays 0.
- Header 0C,01,20,01, payload AA,BB,CC,DD, checksum 2C, out_ready=1 → out_data AA,BB,CC,DD in order; frame_ok=1, hdr_len=01.
- Same frame with checksum 2D → frame_done with frame_ok=0, chk_err=1; the four payload bytes are still output.
- frame_active falls after bytes 01,20 → frame_done, len_err=1, frame_ok=0, hdr_cmd=01, hdr_dest=20, hdr_src=00.
- FIFO_DEPTH=16, out_ready=0, hdr_len=05 (20 payload bytes), correct checksum → ovf_err=1, frame_ok=0; draining yields exactly the first 16 bytes.
- MAPLE_ADDR_FILTER_EN with MY_ADDR=20: frame to dest 01 → no frame_done, no FIFO output, hdr_* unchanged; a following frame to dest 20 completes normally.
